loader_mem_arbiter: RTL and testbench

- Sequences the single external memory port between the iNES game loader and the running NES core.
- While loading, it buffers the loader's unacknowledged byte-write strobes in a 4-entry FIFO and issues them to memory, interleaving the loader's refresh requests.
- After the load completes, it serves core read/write requests and generates periodic refresh itself.
- Sits between GameLoader, the core memory mux and the SDRAM controller.

---
 rtl/loader_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 tb/tb_loader_mem_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/loader_mem_arbiter.sv
// Arbitrates the single memory port between the game loader's buffered byte writes,
// refresh requests and, once loading is done, the NES core's read/write requests.
module loader_mem_arbiter #(
  parameter int ADDR_W         = 22,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT        = 63,
  parameter int REFRESH_PERIOD = 780
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [ADDR_W-1:0]             ld_addr,
  input  logic [7:0]                    ld_data,
  input  logic                          ld_write,
  input  logic                          ld_refresh,
  input  logic                          ld_done,
  input  logic                          core_req,
  input  logic                          core_we,
  input  logic [ADDR_W-1:0]             core_addr,
  input  logic [7:0]                    core_wdata,
  output logic                          core_ack,
  output logic [7:0]                    core_rdata,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [7:0]                    mem_wdata,
  output logic                          mem_refresh,
  input  logic                          mem_ack,
  input  logic [7:0]                    mem_rdata,
  output logic                          overflow,
  output logic                          timeout_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int RF_W   = $clog2(REFRESH_PERIOD);
  localparam int ENT_W  = ADDR_W + 8;

  localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
  localparam logic [RF_W-1:0]   RF_LAST    = RF_W'(REFRESH_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RF,
    CORE
  } state_t;

  state_t             r_state;
  state_t             w_stateNext;

  logic [ENT_W-1:0]   r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wrPtr;
  logic [PTR_W-1:0]   r_rdPtr;
  logic [CNT_W-1:0]   r_count;
  logic               r_overflow;

  logic               r_rfPending;
  logic [RF_W-1:0]    r_rfTimer;

  logic               r_memReq;
  logic               r_memWe;
  logic [ADDR_W-1:0]  r_memAddr;
  logic [7:0]         r_memWdata;
  logic               r_memRefresh;
  logic               r_coreAck;
  logic [7:0]         r_coreRdata;
  logic [WAIT_W-1:0]  r_wait;
  logic               r_timeoutErr;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_rfIssue;
  logic               w_timerHit;
  logic [ENT_W-1:0]   w_head;

  logic               w_memReqNext;
  logic               w_memWeNext;
  logic [ADDR_W-1:0]  w_memAddrNext;
  logic [7:0]         w_memWdataNext;
  logic               w_memRefreshNext;
  logic               w_coreAckNext;
  logic [7:0]         w_coreRdataNext;
  logic [WAIT_W-1:0]  w_waitNext;
  logic               w_timeoutSet;

  assign w_full     = (r_count == DEPTH_C);
  assign w_empty    = (r_count == '0);
  assign w_push     = ld_write && !w_full;
  assign w_head     = r_fifo[r_rdPtr];
  assign w_timerHit = ld_done && (r_rfTimer == RF_LAST);

  // The loader never waits, so a write that finds the buffer full is lost.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wrPtr] <= {ld_addr, ld_data};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
      if (ld_write && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // A request arriving in the same cycle a refresh is issued stays pending.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rfPending <= 1'b0;
      r_rfTimer   <= '0;
    end else begin
      r_rfPending <= (r_rfPending && !w_rfIssue) || ld_refresh || w_timerHit;
      if (!ld_done || w_timerHit) begin
        r_rfTimer <= '0;
      end else begin
        r_rfTimer <= r_rfTimer + RF_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_memReq     <= 1'b0;
      r_memWe      <= 1'b0;
      r_memAddr    <= '0;
      r_memWdata   <= '0;
      r_memRefresh <= 1'b0;
      r_coreAck    <= 1'b0;
      r_coreRdata  <= '0;
      r_wait       <= '0;
      r_timeoutErr <= 1'b0;
    end else begin
      r_state      <= w_stateNext;
      r_memReq     <= w_memReqNext;
      r_memWe      <= w_memWeNext;
      r_memAddr    <= w_memAddrNext;
      r_memWdata   <= w_memWdataNext;
      r_memRefresh <= w_memRefreshNext;
      r_coreAck    <= w_coreAckNext;
      r_coreRdata  <= w_coreRdataNext;
      r_wait       <= w_waitNext;
      r_timeoutErr <= r_timeoutErr || w_timeoutSet;
    end
  end

  // Priority in IDLE: buffered loader writes, then refresh, then the core.
  always_comb begin
    w_stateNext      = r_state;
    w_memReqNext     = r_memReq;
    w_memWeNext      = r_memWe;
    w_memAddrNext    = r_memAddr;
    w_memWdataNext   = r_memWdata;
    w_memRefreshNext = r_memRefresh;
    w_coreAckNext    = 1'b0;
    w_coreRdataNext  = r_coreRdata;
    w_waitNext       = r_wait;
    w_timeoutSet     = 1'b0;
    w_pop            = 1'b0;
    w_rfIssue        = 1'b0;

    case (r_state)
      IDLE: begin
        w_waitNext = '0;
        if (!w_empty) begin
          w_pop          = 1'b1;
          w_memReqNext   = 1'b1;
          w_memWeNext    = 1'b1;
          w_memAddrNext  = w_head[ENT_W-1:8];
          w_memWdataNext = w_head[7:0];
          w_stateNext    = WR;
        end else if (r_rfPending) begin
          w_rfIssue        = 1'b1;
          w_memRefreshNext = 1'b1;
          w_stateNext      = RF;
        end else if (core_req && ld_done) begin
          w_memReqNext   = 1'b1;
          w_memWeNext    = core_we;
          w_memAddrNext  = core_addr;
          w_memWdataNext = core_wdata;
          w_stateNext    = CORE;
        end
      end

      WR, RF, CORE: begin
        if (mem_ack || (r_wait == WAIT_LAST)) begin
          w_memReqNext     = 1'b0;
          w_memWeNext      = 1'b0;
          w_memRefreshNext = 1'b0;
          w_stateNext      = IDLE;
          w_timeoutSet     = !mem_ack;
          if (r_state == CORE) begin
            w_coreAckNext   = 1'b1;
            w_coreRdataNext = mem_ack ? mem_rdata : 8'h00;
          end
        end else begin
          w_waitNext = r_wait + WAIT_W'(1);
        end
      end

      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  assign mem_req     = r_memReq;
  assign mem_we      = r_memWe;
  assign mem_addr    = r_memAddr;
  assign mem_wdata   = r_memWdata;
  assign mem_refresh = r_memRefresh;
  assign core_ack    = r_coreAck;
  assign core_rdata  = r_coreRdata;
  assign overflow    = r_overflow;
  assign timeout_err = r_timeoutErr;
  assign fifo_level  = r_count;

endmodule

// File: tb/tb_loader_mem_arbiter.sv
// Directed bench for loader_mem_arbiter: a scripted memory responder acks after a
// programmable latency and logs every completed access for ordering checks.
module tb_loader_mem_arbiter;

  localparam int ADDR_W = 22;
  localparam logic [31:0] RF_TAG = 32'h8000_0000;

  logic              clk = 1'b0;
  logic              resetn;
  logic [ADDR_W-1:0] ld_addr;
  logic [7:0]        ld_data;
  logic              ld_write;
  logic              ld_refresh;
  logic              ld_done;
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [7:0]        core_wdata;
  logic              core_ack;
  logic [7:0]        core_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_refresh;
  logic              mem_ack;
  logic [7:0]        mem_rdata;
  logic              overflow;
  logic              timeout_err;
  logic [2:0]        fifo_level;

  int          testCount = 0;
  int          failCount = 0;
  logic        ackEnable = 1'b0;
  int          ackLatency = 3;
  logic [7:0]  rdataVal = 8'h00;
  int          busyCycles = 0;
  int          coreAckCount = 0;
  int          conflictCount = 0;
  logic [31:0] memLog [$];

  always #5 clk = ~clk;

  loader_mem_arbiter dut (
    .clk(clk), .resetn(resetn),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_write(ld_write),
    .ld_refresh(ld_refresh), .ld_done(ld_done),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_ack(core_ack), .core_rdata(core_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_refresh(mem_refresh),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .overflow(overflow), .timeout_err(timeout_err), .fifo_level(fifo_level)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Called at a negedge; holds the loader strobes for exactly one clock.
  task automatic applyStimulus(input logic wr, input logic [ADDR_W-1:0] addr,
                               input logic [7:0] data, input logic rf);
    ld_write   = wr;
    ld_addr    = addr;
    ld_data    = data;
    ld_refresh = rf;
    @(negedge clk);
    ld_write   = 1'b0;
    ld_refresh = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Memory model: acks the ackLatency-th cycle a request has been visible.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 8'h00;
      if ((mem_req || mem_refresh) && ackEnable) begin
        busyCycles++;
        if (busyCycles == ackLatency) begin
          mem_ack    = 1'b1;
          mem_rdata  = rdataVal;
          busyCycles = 0;
          memLog.push_back(mem_refresh ? RF_TAG : {1'b0, mem_we, mem_addr, mem_wdata});
        end
      end else begin
        busyCycles = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (core_ack) coreAckCount++;
      if (mem_req && mem_refresh) conflictCount++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rfAt;
    int highCycles;
    int seen;
    logic [31:0] expEntry;

    resetn = 1'b0;
    ld_addr = '0; ld_data = '0; ld_write = 1'b0; ld_refresh = 1'b0; ld_done = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    waitCycles(2);
    checkOutput("rst mem_req", {31'b0, mem_req}, 0);
    checkOutput("rst mem_refresh", {31'b0, mem_refresh}, 0);
    checkOutput("rst core_ack", {31'b0, core_ack}, 0);
    checkOutput("rst core_rdata", {24'b0, core_rdata}, 0);
    checkOutput("rst flags", {30'b0, overflow, timeout_err}, 0);
    checkOutput("rst fifo_level", {29'b0, fifo_level}, 0);
    resetn = 1'b1;
    waitCycles(2);

    // Single loader write, memory acks on the third request cycle.
    ackEnable = 1'b1; ackLatency = 3; memLog.delete();
    applyStimulus(1'b1, 22'h000010, 8'hA5, 1'b0);
    checkOutput("t1 level after push", {29'b0, fifo_level}, 1);
    checkOutput("t1 req not yet", {31'b0, mem_req}, 0);
    waitCycles(1);
    checkOutput("t1 req", {31'b0, mem_req}, 1);
    checkOutput("t1 we", {31'b0, mem_we}, 1);
    checkOutput("t1 addr", {10'b0, mem_addr}, 32'h10);
    checkOutput("t1 data", {24'b0, mem_wdata}, 32'hA5);
    checkOutput("t1 level popped", {29'b0, fifo_level}, 0);
    waitCycles(1);
    checkOutput("t1 req cycle2", {31'b0, mem_req}, 1);
    waitCycles(1);
    checkOutput("t1 req cycle3", {31'b0, mem_req}, 1);
    waitCycles(1);
    checkOutput("t1 req dropped", {31'b0, mem_req}, 0);
    checkOutput("t1 log size", memLog.size(), 1);
    if (memLog.size() >= 1) checkOutput("t1 log entry", memLog[0], {2'b01, 22'h000010, 8'hA5});

    // Six back-to-back writes while a refresh occupies the port: 4 kept, 2 lost.
    waitCycles(2);
    ackLatency = 5; memLog.delete();
    applyStimulus(1'b0, '0, 8'h00, 1'b1);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, ADDR_W'(32'h100 + i), 8'(8'h10 + i), 1'b0);
    end
    checkOutput("t2 overflow", {31'b0, overflow}, 1);
    checkOutput("t2 level full", {29'b0, fifo_level}, 4);
    waitCycles(40);
    checkOutput("t2 log size", memLog.size(), 5);
    if (memLog.size() == 5) begin
      checkOutput("t2 refresh first", memLog[0], RF_TAG);
      for (int i = 0; i < 4; i++) begin
        expEntry = {2'b01, ADDR_W'(32'h100 + i), 8'(8'h10 + i)};
        checkOutput($sformatf("t2 write %0d", i), memLog[i+1], expEntry);
      end
    end
    checkOutput("t2 level drained", {29'b0, fifo_level}, 0);

    // Buffered write beats refresh; core is locked out while loading.
    waitCycles(2);
    ackLatency = 3; memLog.delete(); coreAckCount = 0;
    core_req = 1'b1; core_we = 1'b1; core_addr = 22'h03ABCD; core_wdata = 8'h77;
    applyStimulus(1'b1, 22'h000222, 8'h5A, 1'b1);
    waitCycles(30);
    checkOutput("t3 log size", memLog.size(), 2);
    if (memLog.size() == 2) begin
      checkOutput("t3 write first", memLog[0], {2'b01, 22'h000222, 8'h5A});
      checkOutput("t3 refresh second", memLog[1], RF_TAG);
    end
    checkOutput("t3 no core ack", coreAckCount, 0);
    core_req = 1'b0;

    // Core read after load, then the first self-generated refresh.
    waitCycles(2);
    ackLatency = 2; rdataVal = 8'h3C; coreAckCount = 0;
    core_we = 1'b0; core_addr = 22'h200040; core_req = 1'b1; ld_done = 1'b1;
    waitCycles(1);
    checkOutput("t4 core req", {31'b0, mem_req}, 1);
    checkOutput("t4 core we", {31'b0, mem_we}, 0);
    checkOutput("t4 core addr", {10'b0, mem_addr}, 32'h200040);
    waitCycles(2);
    checkOutput("t4 core_ack", {31'b0, core_ack}, 1);
    checkOutput("t4 core_rdata", {24'b0, core_rdata}, 32'h3C);
    core_req = 1'b0;
    waitCycles(1);
    checkOutput("t4 ack pulse ends", {31'b0, core_ack}, 0);
    checkOutput("t4 rdata held", {24'b0, core_rdata}, 32'h3C);
    checkOutput("t4 ack count", coreAckCount, 1);
    // Pending sets on the 780th edge with ld_done high; issue follows one edge later.
    rfAt = 0;
    for (int k = 5; k <= 900; k++) begin
      @(negedge clk);
      if (mem_refresh) begin
        rfAt = k;
        break;
      end
    end
    checkOutput("t4 refresh cycle", rfAt, 781);
    waitCycles(5);
    ld_done = 1'b0;

    // Unanswered write times out; the next buffered write follows.
    waitCycles(2);
    ackEnable = 1'b0;
    checkOutput("t5 timeout_err before", {31'b0, timeout_err}, 0);
    applyStimulus(1'b1, 22'h000300, 8'hC1, 1'b0);
    applyStimulus(1'b1, 22'h000301, 8'hC2, 1'b0);
    checkOutput("t5 first addr", {10'b0, mem_addr}, 32'h300);
    highCycles = 0;
    while (mem_req && highCycles < 200) begin
      highCycles++;
      @(negedge clk);
    end
    checkOutput("t5 req cycles", highCycles, 63);
    checkOutput("t5 timeout_err", {31'b0, timeout_err}, 1);
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      if (mem_req) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("t5 next issued", seen, 1);
    checkOutput("t5 next addr", {10'b0, mem_addr}, 32'h301);
    checkOutput("t5 next data", {24'b0, mem_wdata}, 32'hC2);
    ackEnable = 1'b1; ackLatency = 3;
    waitCycles(10);
    checkOutput("t5 idle after", {31'b0, mem_req}, 0);

    // Asynchronous reset in the middle of a write.
    waitCycles(2);
    ackEnable = 1'b0;
    applyStimulus(1'b1, 22'h000400, 8'h11, 1'b0);
    applyStimulus(1'b1, 22'h000401, 8'h22, 1'b0);
    checkOutput("t6 in write", {31'b0, mem_req}, 1);
    checkOutput("t6 level", {29'b0, fifo_level}, 1);
    waitCycles(3);
    #2 resetn = 1'b0;
    #1;
    checkOutput("t6 req async clear", {31'b0, mem_req}, 0);
    checkOutput("t6 level clear", {29'b0, fifo_level}, 0);
    checkOutput("t6 flags clear", {30'b0, overflow, timeout_err}, 0);
    @(negedge clk);
    resetn = 1'b1;
    ackEnable = 1'b1;
    highCycles = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (mem_req || mem_refresh) highCycles++;
    end
    checkOutput("t6 nothing issued", highCycles, 0);

    checkOutput("req/refresh overlap", conflictCount, 0);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
